// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-port memory.
// Every output is a register; reset is asynchronous and abandons any access in flight.
module mem_port_arbiter #(
  parameter int AW      = 9,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy,
  output logic          last_grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t                  state_reg, state_next;
  logic [2:0]              cnt_reg, cnt_next;
  logic                    gnt_reg, gnt_next;
  logic                    we_reg, we_next;
  logic                    last_reg, last_next;
  logic [AW-1:0]           addr_reg, addr_next;
  logic [DW-1:0]           din_reg, din_next;
  logic                    write_reg, write_next;
  logic                    read_reg, read_next;
  logic                    busy_reg, busy_next;
  logic [1:0]              ack_reg, ack_next;
  logic [1:0][DW-1:0]      rdata_reg, rdata_next;

  // On a tie the port that did not win last time is served.
  logic          sel;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign sel       = (p0_req && p1_req) ? ~last_reg : p1_req;
  assign sel_we    = sel ? p1_we    : p0_we;
  assign sel_addr  = sel ? p1_addr  : p0_addr;
  assign sel_wdata = sel ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      gnt_reg   <= 1'b0;
      we_reg    <= 1'b0;
      last_reg  <= 1'b1;
      addr_reg  <= '0;
      din_reg   <= '0;
      write_reg <= 1'b0;
      read_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      ack_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      we_reg    <= we_next;
      last_reg  <= last_next;
      addr_reg  <= addr_next;
      din_reg   <= din_next;
      write_reg <= write_next;
      read_reg  <= read_next;
      busy_reg  <= busy_next;
      ack_reg   <= ack_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gnt_next   = gnt_reg;
    we_next    = we_reg;
    last_next  = last_reg;
    addr_next  = addr_reg;
    din_next   = din_reg;
    write_next = 1'b0;
    read_next  = 1'b0;
    ack_next   = '0;
    rdata_next = rdata_reg;

    case (state_reg)
      IDLE: begin
        if (p0_req || p1_req) begin
          gnt_next   = sel;
          last_next  = sel;
          we_next    = sel_we;
          addr_next  = sel_addr;
          din_next   = sel_wdata;
          // Strobes are registered here so they are high exactly during ACCESS.
          write_next = sel_we;
          read_next  = ~sel_we;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (we_reg) begin
          ack_next[gnt_reg] = 1'b1;
          state_next        = RESP;
        end else begin
          cnt_next   = LAT;
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg == 3'd1) begin
          rdata_next[gnt_reg] = mem_dout;
          ack_next[gnt_reg]   = 1'b1;
          state_next          = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign mem_write  = write_reg;
  assign mem_read   = read_reg;
  assign mem_addr   = addr_reg;
  assign mem_din    = din_reg;
  assign busy       = busy_reg;
  assign last_grant = last_reg;
  assign p0_ack     = ack_reg[0];
  assign p1_ack     = ack_reg[1];
  assign p0_rdata   = rdata_reg[0];
  assign p1_rdata   = rdata_reg[1];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each in front of a behavioural 512x16 memory with matching read latency.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [8:0]  p0_addr = '0, p1_addr = '0;
  logic [15:0] p0_wdata = '0, p1_wdata = '0;
  logic        p0_ack, p1_ack, mem_write, mem_read, busy, last_grant;
  logic [15:0] p0_rdata, p1_rdata, mem_din, mem_dout;
  logic [8:0]  mem_addr;

  mem_port_arbiter #(.AW(9), .DW(16), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy), .last_grant(last_grant)
  );

  logic [15:0] mem_a [0:511];
  logic [15:0] rd_a = 16'hDEAD;
  always @(posedge clk) begin
    if (mem_write) mem_a[mem_addr] <= mem_din;
    if (mem_read)  rd_a <= mem_a[mem_addr];
  end
  assign mem_dout = rd_a;

  logic        b_p0_req = 1'b0, b_p0_we = 1'b0, b_p1_req = 1'b0, b_p1_we = 1'b0;
  logic [8:0]  b_p0_addr = '0, b_p1_addr = '0;
  logic [15:0] b_p0_wdata = '0, b_p1_wdata = '0;
  logic        b_p0_ack, b_p1_ack, b_mem_write, b_mem_read, b_busy, b_last_grant;
  logic [15:0] b_p0_rdata, b_p1_rdata, b_mem_din, b_mem_dout;
  logic [8:0]  b_mem_addr;

  mem_port_arbiter #(.AW(9), .DW(16), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .mem_write(b_mem_write), .mem_read(b_mem_read), .mem_addr(b_mem_addr),
    .mem_din(b_mem_din), .mem_dout(b_mem_dout), .busy(b_busy), .last_grant(b_last_grant)
  );

  // Three-stage read pipeline; 0xDEAD marks data that is not yet valid.
  logic [15:0] mem_b [0:511];
  logic [15:0] pipe_b [0:2];
  always @(posedge clk) begin
    if (b_mem_write) mem_b[b_mem_addr] <= b_mem_din;
    pipe_b[0] <= b_mem_read ? mem_b[b_mem_addr] : 16'hDEAD;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_mem_dout = pipe_b[2];

  int total = 0;
  int bad   = 0;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, mem_write, mem_read, p0_ack, p1_ack, last_grant} !== 6'b000001) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000001", {busy, mem_write, mem_read, p0_ack, p1_ack, last_grant});
    end
    total++;
    if ({p0_rdata, p1_rdata} !== 32'h0) begin
      bad++; $display("FAIL reset_rdata: got %h want 00000000", {p0_rdata, p1_rdata});
    end
    total++;
    if ({mem_addr, mem_din} !== 25'h0) begin
      bad++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_din});
    end
    total++;
    if ({b_busy, b_last_grant} !== 2'b01) begin
      bad++; $display("FAIL reset_b: got %b want 01", {b_busy, b_last_grant});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, last_grant} !== 2'b01) begin
      bad++; $display("FAIL reset_release_idle: got %b want 01", {busy, last_grant});
    end
  endtask

  task automatic test_p0_write_read();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h000; p0_wdata = 16'hABCD;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if ({mem_write, mem_read, p0_ack, p1_ack} !== {(k == 1), 1'b0, (k == 2), 1'b0}) begin
        bad++; $display("FAIL p0_wr_cycle%0d: got wr/rd/ack0/ack1=%b want %b", k,
                        {mem_write, mem_read, p0_ack, p1_ack}, {(k == 1), 1'b0, (k == 2), 1'b0});
      end
      if (k == 1) begin
        total++;
        if ({mem_addr, mem_din, last_grant} !== {9'h000, 16'hABCD, 1'b0}) begin
          bad++; $display("FAIL p0_wr_bus: got addr=%h din=%h lg=%b want 000 abcd 0", mem_addr, mem_din, last_grant);
        end
      end
      if (k == 2) p0_req = 1'b0;
      if (k == 3) begin
        total++;
        if (busy !== 1'b0) begin
          bad++; $display("FAIL p0_wr_bubble: got busy=%b want 0", busy);
        end
      end
    end
    p0_req = 1'b1; p0_we = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if ({mem_write, mem_read, p0_ack, p1_ack} !== {1'b0, (k == 1), (k == 3), 1'b0}) begin
        bad++; $display("FAIL p0_rd_cycle%0d: got wr/rd/ack0/ack1=%b want %b", k,
                        {mem_write, mem_read, p0_ack, p1_ack}, {1'b0, (k == 1), (k == 3), 1'b0});
      end
      if (k == 3) begin
        p0_req = 1'b0;
        total++;
        if ({p0_rdata, p1_rdata} !== {16'hABCD, 16'h0000}) begin
          bad++; $display("FAIL p0_rd_data: got p0=%h p1=%h want abcd 0000", p0_rdata, p1_rdata);
        end
      end
    end
  endtask

  task automatic test_p1_boundary();
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h1FF; p1_wdata = 16'h1234;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if ({mem_write, mem_read, p0_ack, p1_ack} !== {(k == 1), 1'b0, 1'b0, (k == 2)}) begin
        bad++; $display("FAIL p1_wr_cycle%0d: got wr/rd/ack0/ack1=%b want %b", k,
                        {mem_write, mem_read, p0_ack, p1_ack}, {(k == 1), 1'b0, 1'b0, (k == 2)});
      end
      if (k == 1) begin
        total++;
        if ({mem_addr, mem_din, last_grant} !== {9'h1FF, 16'h1234, 1'b1}) begin
          bad++; $display("FAIL p1_wr_bus: got addr=%h din=%h lg=%b want 1ff 1234 1", mem_addr, mem_din, last_grant);
        end
      end
      if (k == 2) p1_req = 1'b0;
    end
    p1_req = 1'b1; p1_we = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if ({mem_write, mem_read, p0_ack, p1_ack} !== {1'b0, (k == 1), 1'b0, (k == 3)}) begin
        bad++; $display("FAIL p1_rd_cycle%0d: got wr/rd/ack0/ack1=%b want %b", k,
                        {mem_write, mem_read, p0_ack, p1_ack}, {1'b0, (k == 1), 1'b0, (k == 3)});
      end
      if (k == 3) begin
        p1_req = 1'b0;
        total++;
        if ({p0_rdata, p1_rdata} !== {16'hABCD, 16'h1234}) begin
          bad++; $display("FAIL p1_rd_data: got p0=%h p1=%h want abcd 1234", p0_rdata, p1_rdata);
        end
      end
    end
  endtask

  task automatic write_word(input bit port, input logic [8:0] addr, input logic [15:0] data);
    bit got = 1'b0;
    if (port) begin p1_req = 1'b1; p1_we = 1'b1; p1_addr = addr; p1_wdata = data; end
    else      begin p0_req = 1'b1; p0_we = 1'b1; p0_addr = addr; p0_wdata = data; end
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if ((port ? p1_ack : p0_ack) === 1'b1) got = 1'b1;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    total++;
    if (!got) begin
      bad++; $display("FAIL write_word_ack: port %0d got no ack want ack within 10 cycles", port);
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    logic [8:0]  exp_addr;
    logic [15:0] exp_data, got_data;
    logic [1:0]  exp_ack;
    write_word(1'b0, 9'h005, 16'h0005);
    write_word(1'b1, 9'h00A, 16'h000A);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h005;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h00A;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      total++;
      if ((p0_ack && p1_ack) || (mem_read && mem_write)) begin
        bad++; $display("FAIL rr_exclusive: got ack=%b%b strobes=%b%b want no overlap", p1_ack, p0_ack, mem_write, mem_read);
      end
      exp_addr = n[0] ? 9'h00A : 9'h005;
      exp_data = n[0] ? 16'h000A : 16'h0005;
      exp_ack  = n[0] ? 2'b10 : 2'b01;
      if (mem_read) begin
        total++;
        if (mem_addr !== exp_addr) begin
          bad++; $display("FAIL rr_addr%0d: got %h want %h", n, mem_addr, exp_addr);
        end
      end
      if (p0_ack || p1_ack) begin
        got_data = p1_ack ? p1_rdata : p0_rdata;
        total++;
        if ({p1_ack, p0_ack} !== exp_ack || got_data !== exp_data) begin
          bad++; $display("FAIL rr_grant%0d: got ack=%b data=%h want ack=%b data=%h", n, {p1_ack, p0_ack}, got_data, exp_ack, exp_data);
        end
        n++;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    total++;
    if (n != 4) begin
      bad++; $display("FAIL rr_count: got %0d acks want 4 within 40 cycles", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    // Abort once in ACCESS (strobe high) and once in WAIT.
    for (int ab = 1; ab <= 2; ab++) begin
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h005;
      repeat (ab) @(negedge clk);
      if (ab == 1) begin
        total++;
        if (mem_read !== 1'b1) begin
          bad++; $display("FAIL abort_pre_read: got %b want 1", mem_read);
        end
      end
      rst = 1'b1;
      #1;
      total++;
      if ({busy, mem_read, mem_write, p0_ack, last_grant} !== 5'b00001) begin
        bad++; $display("FAIL abort%0d_async: got busy/rd/wr/ack/lg=%b want 00001", ab, {busy, mem_read, mem_write, p0_ack, last_grant});
      end
      p0_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        total++;
        if ({p0_ack, busy} !== 2'b00) begin
          bad++; $display("FAIL abort%0d_no_ack: got ack/busy=%b want 00", ab, {p0_ack, busy});
        end
      end
      total++;
      if (p0_rdata !== 16'h0000) begin
        bad++; $display("FAIL abort%0d_rdata_cleared: got %h want 0000", ab, p0_rdata);
      end
    end
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h005;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if ({mem_read, p0_ack} !== {(k == 1), (k == 3)}) begin
        bad++; $display("FAIL reissue_cycle%0d: got rd/ack=%b want %b", k, {mem_read, p0_ack}, {(k == 1), (k == 3)});
      end
    end
    p0_req = 1'b0;
    total++;
    if (p0_rdata !== 16'h0005) begin
      bad++; $display("FAIL reissue_data: got %h want 0005", p0_rdata);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency3();
    b_p1_req = 1'b1; b_p1_we = 1'b1; b_p1_addr = 9'h0C8; b_p1_wdata = 16'hCAFE;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if ({b_mem_write, b_p1_ack} !== {(k == 1), (k == 2)}) begin
        bad++; $display("FAIL lat3_wr_cycle%0d: got wr/ack=%b want %b", k, {b_mem_write, b_p1_ack}, {(k == 1), (k == 2)});
      end
      if (k == 2) b_p1_req = 1'b0;
    end
    b_p1_req = 1'b1; b_p1_we = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      total++;
      if ({b_mem_read, b_p0_ack, b_p1_ack} !== {(k == 1), 1'b0, (k == 5)}) begin
        bad++; $display("FAIL lat3_rd_cycle%0d: got rd/ack0/ack1=%b want %b", k,
                        {b_mem_read, b_p0_ack, b_p1_ack}, {(k == 1), 1'b0, (k == 5)});
      end
      if (k == 5) begin
        b_p1_req = 1'b0;
        total++;
        if (b_p1_rdata !== 16'hCAFE) begin
          bad++; $display("FAIL lat3_rd_data: got %h want cafe", b_p1_rdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_p0_write_read();
    test_p1_boundary();
    test_round_robin();
    test_reset_mid();
    test_latency3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
